// File: rtl/kamacore_stage_ex.sv
// kamacore execute stage: single-cycle ALU plus optional iterative radix-2 divider.
// Define KAMACORE_DIV_EN to build the divider; otherwise ops 12-15 yield 0 with no stall.
package kamacore_pkg;
  localparam int CPU_WIDTH = 32;

  typedef struct packed {
    logic                 valid;
    logic [31:0]          instruction;
    logic [CPU_WIDTH-1:0] operand_a;
    logic [CPU_WIDTH-1:0] operand_b;
    logic [3:0]           alu_op;
  } id_ex_t;

  typedef struct packed {
    logic                 valid;
    logic [31:0]          instruction;
    logic [CPU_WIDTH-1:0] alu_result;
  } ex_mem_t;
endpackage

module kamacore_stage_ex
  import kamacore_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  id_ex_t  pipeline_id_ex,
  input  logic    flush,
  output logic    stall,
  output ex_mem_t pipeline_ex_mem
);
  localparam int W  = CPU_WIDTH;
  localparam int SW = $clog2(W);
  localparam logic [W-1:0] INT_MIN = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0]  a, b, alu_res;
  logic [3:0]    op;
  logic [SW-1:0] sh;
  ex_mem_t       ex_nxt;

  assign a  = pipeline_id_ex.operand_a;
  assign b  = pipeline_id_ex.operand_b;
  assign op = pipeline_id_ex.alu_op;
  assign sh = b[SW-1:0];

`ifdef KAMACORE_DIV_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_e;
  div_state_e    state, state_nxt;
  logic [SW-1:0] cnt;
  logic [W-1:0]  quo, rem, dvs, a_abs, b_abs, q_fix, r_fix, div_res;
  logic [W:0]    trial, diff;
  logic          neg_q, neg_r, is_rem, ge;
  logic          is_div, op_signed, div_zero, div_ovf, div_start;

  assign op_signed = op[1];
  assign is_div    = pipeline_id_ex.valid && (op[3:2] == 2'b11);
  assign div_zero  = (b == '0);
  assign div_ovf   = op_signed && (a == INT_MIN) && (b == '1);
  assign div_start = is_div && !div_zero && !div_ovf;
  assign a_abs     = (op_signed && a[W-1]) ? -a : a;
  assign b_abs     = (op_signed && b[W-1]) ? -b : b;

  // One restoring step: shift the next dividend bit into the partial remainder.
  assign trial = {rem, quo[W-1]};
  assign diff  = trial - {1'b0, dvs};
  assign ge    = !diff[W];

  assign q_fix   = neg_q ? -quo : quo;
  assign r_fix   = neg_r ? -rem : rem;
  assign div_res = is_rem ? r_fix : q_fix;

  assign stall = rst && !flush && ((state == IDLE && div_start) || state == RUN);

  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (div_start) state_nxt = RUN;
        RUN:     if (cnt == '0) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_rem <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && div_start && !flush) begin
        quo    <= a_abs;
        rem    <= '0;
        dvs    <= b_abs;
        neg_q  <= op_signed && (a[W-1] ^ b[W-1]);
        neg_r  <= op_signed && a[W-1];
        is_rem <= op[0];
        cnt    <= SW'(W-1);
      end else if (state == RUN) begin
        rem <= ge ? diff[W-1:0] : trial[W-1:0];
        quo <= {quo[W-2:0], ge};
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
    end
  end
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    alu_res = '0;
    case (op)
      4'd0:  alu_res = a + b;
      4'd1:  alu_res = a - b;
      4'd2:  alu_res = a & b;
      4'd3:  alu_res = a | b;
      4'd4:  alu_res = a ^ b;
      4'd5:  alu_res = a << sh;
      4'd6:  alu_res = a >> sh;
      4'd7:  alu_res = $signed(a) >>> sh;
      4'd8:  alu_res = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
      4'd9:  alu_res = {{(W-1){1'b0}}, a < b};
      4'd10: alu_res = a * b;
`ifdef KAMACORE_DIV_EN
      // Only the single-cycle special cases reach the output from here.
      4'd12, 4'd13, 4'd14, 4'd15:
        alu_res = div_zero ? (op[0] ? a : '1) : (op[0] ? '0 : INT_MIN);
`endif
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    ex_nxt = '0;
    if (flush || stall) ex_nxt = '0;
`ifdef KAMACORE_DIV_EN
    else if (state == DONE) ex_nxt = '{valid: 1'b1, instruction: pipeline_id_ex.instruction, alu_result: div_res};
`endif
    else if (pipeline_id_ex.valid)
      ex_nxt = '{valid: 1'b1, instruction: pipeline_id_ex.instruction, alu_result: alu_res};
  end

  always_ff @(posedge clk) begin
    if (!rst) pipeline_ex_mem <= '0;
    else      pipeline_ex_mem <= ex_nxt;
  end
endmodule

// File: doc/kamacore_stage_ex.md
# kamacore_stage_ex

Execute stage of the kamacore five-stage pipeline. It sits between decode and memory: it consumes the operands and ALU opcode latched in `pipeline_id_ex`, computes the result, and registers it into `pipeline_ex_mem`, whose `alu_result` the memory stage uses as its data-memory address. Single-cycle ops complete in one clock. Divide/remainder ops run on an iterative radix-2 divider that stalls decode and inserts bubbles downstream.

## Interface
Parameters:
- `CPU_WIDTH`, default 32 (package constant): datapath width. Must be a power of two, ≥8.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-low.
- `pipeline_id_ex`  interface  —  consumed fields:
  - `valid` (1)
  - `instruction` (32)
  - `operand_a` (CPU_WIDTH)
  - `operand_b` (CPU_WIDTH)
  - `alu_op` (4)
- `pipeline_ex_mem`  interface  —  produced fields, all registered:
  - `valid` (1)
  - `instruction` (32)
  - `alu_result` (CPU_WIDTH)
- `flush`  in  1  kill the in-flight op (branch redirect).
- `stall`  out  1  combinational; decode holds `pipeline_id_ex` while high.

## Operation
- `alu_op` encoding (W = CPU_WIDTH; shifts use `operand_b[log2 W-1:0]`):
  - 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR.
  - 5 SLL; 6 SRL; 7 SRA.
  - 8 SLT (signed); 9 SLTU. Result is 1 or 0, zero-extended.
  - 10 MUL (low W bits of product).
  - 11 reserved: result 0.
  - 12 DIVU; 13 REMU; 14 DIV; 15 REM.
- Arithmetic wraps modulo 2^W. No flags.
- Divide FSM states: IDLE, RUN, DONE.
  - IDLE → RUN: valid div op (12–15) with a nonzero divisor and no signed overflow. Capture absolute values, the sign info, and the op. Load counter = W−1.
  - RUN: one restoring step per cycle. At counter==0 go to DONE; otherwise decrement.
  - DONE: apply sign corrections, write the result, go to IDLE.
- Div special cases complete in a single cycle with no stall:
  - Divisor 0: quotient = all ones; remainder = dividend.
  - Signed `INT_MIN / −1`: quotient = INT_MIN; remainder = 0.
- Signed results: quotient sign = sign(a) XOR sign(b); remainder takes the sign of the dividend.
- `stall` = 1 in IDLE when starting a divide, and in RUN. It is 0 in DONE and in all other cases.
- While `stall` = 1: `pipeline_ex_mem` gets a bubble (`valid` = 0, `instruction` = 0, `alu_result` = 0).
- In DONE, `pipeline_id_ex` still holds the same div op. The FSM does not restart on it; it returns to IDLE.
- `valid` = 0 input: output is a bubble and the FSM stays in IDLE.
- `flush` = 1: the FSM goes to IDLE, the next `pipeline_ex_mem` value is a bubble, and `stall` = 0 that cycle. Flush has priority over every other event.
- Reset (`rst` = 0 at a clock edge), including mid-divide: FSM → IDLE, counter = 0, all `pipeline_ex_mem` fields = 0. `stall` = 0 while in reset.

## Timing
- Non-div op presented in cycle n: result appears in `pipeline_ex_mem` after edge n+1. Throughput is one per cycle.
- Divide presented in cycle 0:
  - `stall` is high in cycles 0..W.
  - Cycle W+1 is DONE, with `stall` = 0.
  - The result appears in `pipeline_ex_mem` after the edge ending cycle W+1, which is W+2 cycles of latency.
  - W+1 bubbles are emitted before the result.
- Back-to-back divides: the second one enters IDLE→RUN in the cycle after DONE, with no extra gap.
- Flush in any RUN cycle: the result is never written, and the next instruction is accepted the following cycle.

## Configuration
- `KAMACORE_DIV_EN` defined: the divider FSM is instantiated as described above.
- `KAMACORE_DIV_EN` undefined:
  - No FSM or divider logic.
  - `stall` is tied to 0.
  - Ops 12–15 complete in one cycle with `alu_result` = 0, treated like a reserved opcode.
  - All other behaviour is unchanged.

## Test plan
- ADD `0xFFFFFFFF` + `0x00000001` → `alu_result` `0x00000000` one edge later. SRA `0x80000000` by 4 → `0xF8000000`.
- SLT `0xFFFFFFFF`, `1` → 1. SLTU with the same operands → 0. MUL `0x00010000` × `0x00010000` → `0x00000000`.
- DIV −7 / 2 → −3 (`0xFFFFFFFD`) and REM → −1. `stall` is high for exactly 33 cycles and there are 33 bubbles; the result appears at the 34th edge (W=32).
- DIVU x / 0 → `0xFFFFFFFF`; REMU 5 / 0 → 5. DIV `0x80000000` / −1 → `0x80000000`. All complete in one cycle with `stall` never asserted.
- Flush at RUN cycle 10 of a DIVU → no result written, FSM back to IDLE. An ADD presented next cycle completes normally.
- Assert `rst` low mid-divide → all `pipeline_ex_mem` fields are 0 and `stall` = 0. After release, a DIVU 100 / 7 → 14 with full latency.
